// File: rtl/float_accumulator.sv
// float_accumulator: sums the float beats of each packet using an external
// pipelined adder of fixed latency ADD_LATENCY.
//   clk, resetn      : clock, asynchronous active-low reset
//   s_valid/s_ready  : input beat handshake; s_data operand, s_last ends packet
//   addA, addB       : operands to the external adder
//   addSum           : adder result for operands issued ADD_LATENCY cycles ago
//   m_valid/m_ready  : packet sum handshake; m_data packet sum
module float_accumulator #(
    parameter int MANTISSA_SIZE = 23,
    parameter int EXPONENT_SIZE = 8,
    parameter int ADD_LATENCY   = 4,
    localparam int FLOAT_SIZE   = 1 + EXPONENT_SIZE + MANTISSA_SIZE
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [FLOAT_SIZE-1:0] s_data,
    input  logic                  s_last,
    output logic [FLOAT_SIZE-1:0] addA,
    output logic [FLOAT_SIZE-1:0] addB,
    input  logic [FLOAT_SIZE-1:0] addSum,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FLOAT_SIZE-1:0] m_data
);
    localparam int SW = $clog2(ADD_LATENCY);
    localparam int CW = $clog2(ADD_LATENCY + 1);

    typedef enum logic [1:0] {ACC, COLLECT, REDUCE, OUT} state_t;

    state_t                  state_q, state_d;
    logic                    run_q;
    logic [SW-1:0]           slot_q, slot_d, slot_next;
    logic [ADD_LATENCY-1:0]  live_q, live_d;
    logic [FLOAT_SIZE-1:0]   bank_q [ADD_LATENCY];
    logic [FLOAT_SIZE-1:0]   bank_d [ADD_LATENCY];
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [SW-1:0]           k_q, k_d;
    logic [FLOAT_SIZE-1:0]   r_q, r_d;

    assign slot_next = (slot_q == SW'(ADD_LATENCY - 1)) ? '0 : slot_q + 1'b1;
    assign m_data    = r_q;

    // Each slot carries an independent partial sum around the adder pipeline;
    // COLLECT drains them into bank, REDUCE folds bank into r one add at a time.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        live_d  = live_q;
        bank_d  = bank_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        r_d     = r_q;
        addA    = '0;
        addB    = '0;
        s_ready = 1'b0;
        m_valid = 1'b0;
        case (state_q)
            ACC: if (run_q) begin
                s_ready = 1'b1;
                addA    = s_valid ? s_data : '0;
                addB    = live_q[slot_q] ? addSum : '0;
                slot_d  = slot_next;
                if (s_valid) begin
                    live_d[slot_q] = 1'b1;
                    if (s_last) begin
                        state_d = COLLECT;
                        cnt_d   = '0;
                    end
                end
            end
            COLLECT: begin
                slot_d         = slot_next;
                bank_d[slot_q] = live_q[slot_q] ? addSum : '0;
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == CW'(ADD_LATENCY - 1)) begin
                    state_d = REDUCE;
                    cnt_d   = '0;
                    k_d     = SW'(1);
                end
            end
            REDUCE: begin
                // bank[0] feeds the first add directly, so r need not be preloaded.
                if (cnt_q == '0) begin
                    addA = (k_q == SW'(1)) ? bank_q[0] : r_q;
                    addB = bank_q[k_q];
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(ADD_LATENCY)) begin
                    r_d   = addSum;
                    cnt_d = '0;
                    k_d   = k_q + 1'b1;
                    if (k_q == SW'(ADD_LATENCY - 1)) state_d = OUT;
                end
            end
            OUT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    state_d = ACC;
                    live_d  = '0;
                    slot_d  = '0;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ACC;
            run_q   <= 1'b0;
            slot_q  <= '0;
            live_q  <= '0;
            bank_q  <= '{default: '0};
            cnt_q   <= '0;
            k_q     <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            slot_q  <= slot_d;
            live_q  <= live_d;
            bank_q  <= bank_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            r_q     <= r_d;
        end
    end
endmodule
